// File: rtl/uart_pkg.sv
// uart_pkg: UART register map, STAT/CTRL bit positions and scheduler FSM encoding
package uart_pkg;
  localparam logic [31:0] UART_CTRL = 32'h0;
  localparam logic [31:0] UART_STAT = 32'h4;
  localparam logic [31:0] UART_DATA = 32'h8;
  localparam int STAT_TX_RDY = 0;
  localparam int STAT_TX_DONE = 1;
  localparam int CTRL_UART_EN = 0;
  localparam int CTRL_TX_EN = 1;
  localparam int CTRL_BAUD_LSB = 5;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ARB, S_POLL_RD, S_POLL_WAIT, S_WRITE} state_t;
  function automatic logic [31:0] ctrl_word(input logic [1:0] baud);
    ctrl_word = 32'(1 << CTRL_UART_EN) | 32'(1 << CTRL_TX_EN) | (32'(baud) << CTRL_BAUD_LSB);
  endfunction
endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after index last
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index
);
  // descending scan so the nearest candidate after last is written last and wins
  always_comb begin
    index = '0;
    for (int i = N; i >= 1; i--) begin
      logic [IW-1:0] k;
      k = IW'((int'(last) + i) % N);
      if (req[k]) index = k;
    end
    gnt = |req ? N'(1) << index : '0;
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates byte requesters and pushes each byte into a memory-mapped UART.
// Define UART_TX_SCHED_TIMEOUT_EN to bound STAT polling at POLL_MAX reads and flag err.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter logic [1:0] BAUD_SEL = 2'd0,
  parameter int         POLL_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       m_waddr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wen,
  input  logic              m_wready,
  output logic [31:0]       m_raddr,
  output logic              m_ren,
  input  logic [31:0]       m_rdata,
  input  logic              m_rvalid,
  output logic              busy,
  output logic              err
);
  localparam int IW = $clog2(NREQ);
  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   w_idx;
  logic [NREQ-1:0] w_gnt;
  logic [7:0]      r_byte;
  logic            r_wen;
  logic            r_ren;
  logic [31:0]     r_waddr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [31:0]     r_raddr;
  logic            w_timeout;
  logic            w_unused;

  rr_arbiter #(.N(NREQ)) u_arb (.req(req_valid), .last(r_last), .gnt(w_gnt), .index(w_idx));

  assign req_ready = (r_state == S_ARB) ? w_gnt : '0;
  assign busy      = r_state != S_IDLE;
  assign m_wen     = r_wen;
  assign m_ren     = r_ren;
  assign m_waddr   = r_waddr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_raddr   = r_raddr;
  assign w_unused  = ^{m_rdata[31:STAT_TX_DONE+1], m_rdata[STAT_TX_DONE]} ^ (POLL_MAX < 1);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(POLL_MAX + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign w_timeout = r_cnt == CW'(POLL_MAX);
  assign err       = r_err;
  // r_cnt holds the number of STAT reads issued for the current byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_ARB) begin
      r_cnt <= CW'(1);
    end else if (r_state == S_POLL_WAIT && m_rvalid && !m_rdata[STAT_TX_RDY]) begin
      if (w_timeout) r_err <= 1'b1;
      else r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // bus outputs are loaded on the transition into the state that owns them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_raddr <= '0;
      r_last  <= IW'(NREQ - 1);
      r_byte  <= '0;
    end else begin
      case (r_state)
        S_INIT: if (r_wen && m_wready) begin
          r_wen   <= 1'b0;
          r_waddr <= '0;
          r_wdata <= '0;
          r_wstrb <= '0;
          r_state <= S_IDLE;
        end else begin
          r_wen   <= 1'b1;
          r_waddr <= UART_CTRL;
          r_wdata <= ctrl_word(BAUD_SEL);
          r_wstrb <= 4'hF;
        end
        S_IDLE: if (|req_valid) r_state <= S_ARB;
        S_ARB: if (|req_valid) begin
          r_byte  <= req_data[8*w_idx +: 8];
          r_last  <= w_idx;
          r_ren   <= 1'b1;
          r_raddr <= UART_STAT;
          r_state <= S_POLL_RD;
        end else begin
          r_state <= S_IDLE;
        end
        S_POLL_RD: begin
          r_ren   <= 1'b0;
          r_raddr <= '0;
          r_state <= S_POLL_WAIT;
        end
        S_POLL_WAIT: if (m_rvalid) begin
          if (m_rdata[STAT_TX_RDY]) begin
            r_wen   <= 1'b1;
            r_waddr <= UART_DATA;
            r_wdata <= {24'b0, r_byte};
            r_wstrb <= 4'h1;
            r_state <= S_WRITE;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_ren   <= 1'b1;
            r_raddr <= UART_STAT;
            r_state <= S_POLL_RD;
          end
        end
        S_WRITE: if (m_wready) begin
          r_wen   <= 1'b0;
          r_waddr <= '0;
          r_wdata <= '0;
          r_wstrb <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized requesters and UART slave against a round-robin transfer model
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam logic [1:0] BS = 2'd2;
  localparam int PMAX = 3;
  localparam logic [31:0] CTRL_EXP = 32'h3 | (32'(BS) << 5);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic [31:0] m_waddr, m_wdata, m_raddr;
  logic [3:0] m_wstrb;
  logic m_wen, m_ren, busy, err;
  logic m_wready = 1'b0;
  logic m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .BAUD_SEL(BS), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wen(m_wen), .m_wready(m_wready),
    .m_raddr(m_raddr), .m_ren(m_ren), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;
  int wr_lat = 2, wcnt = 2, rd_lat = 1, rd_pend = 0;
  int zeros_left = 0, armed = 0;
  bit rand_zeros = 0, hold_wready = 0, inject = 0, auto_req = 0;
  int n_reads = 0;
  int req_pop = -1;
  int m_last = NREQ - 1;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0] wq_strb[$];
  int gq[$];
  int exp_g[$];
  logic [7:0] exp_d[$];
  logic [7:0] rq[NREQ][$];

  function automatic int next_grant(input logic [NREQ-1:0] mask, input int last);
    for (int d = 1; d <= NREQ; d++) if (mask[(last + d) % NREQ]) return (last + d) % NREQ;
    return -1;
  endfunction

  // expected grant/byte order: every requester with bytes left is pending at each arbitration
  task automatic model_order();
    int pos[NREQ];
    logic [NREQ-1:0] mask;
    int g;
    exp_g.delete();
    exp_d.delete();
    foreach (pos[i]) pos[i] = 0;
    forever begin
      for (int i = 0; i < NREQ; i++) mask[i] = pos[i] < rq[i].size();
      if (mask == 0) break;
      g = next_grant(mask, m_last);
      exp_g.push_back(g);
      exp_d.push_back(rq[g][pos[g]]);
      pos[g]++;
      m_last = g;
    end
  endtask

  task automatic present(input int i);
    req_valid[i] = rq[i].size() > 0;
    req_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0] : 8'($urandom);
  endtask

  task automatic clr();
    wq_addr.delete();
    wq_data.delete();
    wq_strb.delete();
    gq.delete();
    n_reads = 0;
  endtask

  // one cycle: monitor outputs, then advance requesters and the UART slave
  task automatic tick();
    @(negedge clk);
    checks++;
    if ((m_wen && m_ren) || !$onehot0(req_ready) ||
        (!busy && (m_wen || m_ren || m_waddr != 0 || m_wdata != 0 || m_wstrb != 0 || m_raddr != 0))) begin
      errors++;
      $display("FAIL bus_rules: wen=%b ren=%b ready=%b busy=%b waddr=%h raddr=%h, required exclusive bus, one-hot ready, zero idle outputs",
               m_wen, m_ren, req_ready, busy, m_waddr, m_raddr);
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) gq.push_back(i);
    if (req_pop >= 0) begin
      rq[req_pop].delete(0);
      present(req_pop);
      req_pop = -1;
    end
    if (auto_req) for (int i = 0; i < NREQ; i++) if (req_ready[i]) req_pop = i;
    m_rvalid = 1'b0;
    m_rdata = $urandom;
    if (!rst) begin
      m_wready = 1'b0;
      rd_pend = 0;
      wcnt = wr_lat;
    end else begin
      if (m_wready) m_wready = 1'b0;
      else if (m_wen && !hold_wready) begin
        if (wcnt > 0) wcnt--;
        else begin
          m_wready = 1'b1;
          wq_addr.push_back(m_waddr);
          wq_data.push_back(m_wdata);
          wq_strb.push_back(m_wstrb);
          wcnt = wr_lat;
        end
      end
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin
          m_rvalid = 1'b1;
          m_rdata[0] = zeros_left == 0;
          if (zeros_left > 0) zeros_left--;
          else if (rand_zeros) begin
            zeros_left = $urandom_range(0, 2);
            armed += zeros_left;
          end
        end
      end
      if (m_ren) begin
        n_reads++;
        rd_pend = rd_lat;
        checks++;
        if (m_raddr !== 32'h4) begin
          errors++;
          $display("FAIL read_addr: got %h expected 00000004", m_raddr);
        end
      end
      if (inject) begin
        inject = 0;
        m_rvalid = 1'b1;
        m_rdata = 32'h1;
      end
    end
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    do begin tick(); n++; end while (busy && n < 100);
    checks++;
    if (busy) begin errors++; $display("FAIL %s: busy=%b after %0d cycles expected 0", name, busy, n); end
  endtask

  task automatic run_until_idle(input string name);
    int n = 0;
    do begin tick(); n++; end while ((busy || req_valid != 0) && n < 3000);
    checks++;
    if (busy || req_valid != 0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b valid=%b expected idle", name, busy, req_valid);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    req_pop = -1;
    tick();
    tick();
    rst = 1'b1;
    m_last = NREQ - 1;
    wait_not_busy("reset_init");
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({m_wen, m_ren, busy, err} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_ctl: wen,ren,busy,err=%b expected 0010", {m_wen, m_ren, busy, err});
    end
    checks++;
    if ({m_waddr, m_wdata, m_raddr, m_wstrb, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_bus: waddr=%h wdata=%h raddr=%h wstrb=%h ready=%b expected all 0",
               m_waddr, m_wdata, m_raddr, m_wstrb, req_ready);
    end
    clr();
    rst = 1'b1;
    wait_not_busy("init_done");
    checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 32'h0 || wq_data[0] !== CTRL_EXP || wq_strb[0] !== 4'hF) begin
      errors++;
      $display("FAIL init_write: count=%0d addr=%h data=%h strb=%h expected 1 write 0 %h F",
               wq_addr.size(), wq_addr.size() ? wq_addr[0] : 0, wq_data.size() ? wq_data[0] : 0,
               wq_strb.size() ? wq_strb[0] : 0, CTRL_EXP);
    end
    checks++;
    if (n_reads != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL init_quiet: reads=%0d err=%b expected 0 0", n_reads, err);
    end
  endtask

  task automatic test_single();
    clr();
    rand_zeros = 0;
    zeros_left = 2;
    rd_lat = 1;
    rq[0].push_back(8'h41);
    model_order();
    present(0);
    auto_req = 1;
    run_until_idle("single");
    checks++;
    if (n_reads != 3) begin errors++; $display("FAIL single_reads: got %0d expected 3", n_reads); end
    checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 32'h8 || wq_data[0] !== 32'h41 || wq_strb[0] !== 4'h1) begin
      errors++;
      $display("FAIL single_write: count=%0d addr=%h data=%h expected 1 write 8 00000041 strb 1",
               wq_addr.size(), wq_addr.size() ? wq_addr[0] : 0, wq_data.size() ? wq_data[0] : 0);
    end
    checks++;
    if (gq.size() != 1 || gq[0] != exp_g[0]) begin
      errors++;
      $display("FAIL single_grant: count=%0d first=%0d expected 1 grant of %0d", gq.size(), gq.size() ? gq[0] : -1, exp_g[0]);
    end
  endtask

  task automatic test_rr_static();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    do_reset();
    clr();
    auto_req = 0;
    zeros_left = 0;
    req_valid = '1;
    req_data = 32'h13121110;
    do begin tick(); n++; end while (gq.size() < 5 && n < 500);
    tick();
    req_valid = '0;
    run_until_idle("rr_static");
    m_last = 0;
    checks++;
    if (gq.size() != 5 || wq_data.size() != 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d writes=%0d expected 5 5", gq.size(), wq_data.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gq[k] != exp_order[k] || wq_data[k] !== 32'h10 + 32'(exp_order[k]) || wq_addr[k] !== 32'h8) begin
          errors++;
          $display("FAIL rr_order[%0d]: grant=%0d data=%h expected grant %0d data %h",
                   k, gq[k], wq_data[k], exp_order[k], 32'h10 + 32'(exp_order[k]));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int nbytes = 0;
      clr();
      for (int i = 0; i < NREQ; i++) begin
        rq[i].delete();
        repeat ($urandom_range(0, 3)) begin rq[i].push_back(8'($urandom)); nbytes++; end
      end
      if (nbytes == 0) begin rq[1].push_back(8'($urandom)); nbytes = 1; end
      model_order();
      wr_lat = $urandom_range(0, 3);
      rd_lat = $urandom_range(1, 3);
      rand_zeros = 1;
      zeros_left = $urandom_range(0, 2);
      armed = zeros_left;
      for (int i = 0; i < NREQ; i++) present(i);
      auto_req = 1;
      run_until_idle("random");
      checks++;
      if (gq.size() != exp_g.size() || wq_data.size() != exp_d.size()) begin
        errors++;
        $display("FAIL rand_count[%0d]: grants=%0d writes=%0d expected %0d %0d", r, gq.size(), wq_data.size(), exp_g.size(), exp_d.size());
      end else begin
        for (int k = 0; k < exp_g.size(); k++) begin
          checks++;
          if (gq[k] != exp_g[k] || wq_data[k] !== {24'b0, exp_d[k]} || wq_addr[k] !== 32'h8 || wq_strb[k] !== 4'h1) begin
            errors++;
            $display("FAIL rand_xfer[%0d.%0d]: grant=%0d addr=%h data=%h strb=%h expected grant %0d addr 8 data %h strb 1",
                     r, k, gq[k], wq_addr[k], wq_data[k], wq_strb[k], exp_g[k], exp_d[k]);
          end
        end
      end
      checks++;
      if (n_reads != armed - zeros_left + nbytes) begin
        errors++;
        $display("FAIL rand_reads[%0d]: got %0d expected %0d", r, n_reads, armed - zeros_left + nbytes);
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL rand_err[%0d]: got %b expected 0", r, err); end
    end
    rand_zeros = 0;
    zeros_left = 0;
    wr_lat = 2;
    rd_lat = 1;
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    clr();
    hold_wready = 1;
    zeros_left = 0;
    rq[2].push_back(8'h5A);
    present(2);
    auto_req = 1;
    do begin tick(); n++; end while (!(m_wen && m_waddr == 32'h8) && n < 200);
    checks++;
    if (!(m_wen && m_waddr == 32'h8)) begin errors++; $display("FAIL midwr_reach: wen=%b waddr=%h expected 1 8", m_wen, m_waddr); end
    rst = 1'b0;
    #1;
    checks++;
    if (m_wen !== 1'b0 || busy !== 1'b1 || m_wdata !== '0) begin
      errors++;
      $display("FAIL midwr_async: wen=%b busy=%b wdata=%h expected 0 1 0", m_wen, busy, m_wdata);
    end
    tick();
    tick();
    hold_wready = 0;
    clr();
    rst = 1'b1;
    m_last = NREQ - 1;
    wait_not_busy("midwr_init");
    repeat (5) tick();
    checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 32'h0 || wq_data[0] !== CTRL_EXP) begin
      errors++;
      $display("FAIL midwr_writes: count=%0d first_addr=%h expected only INIT write to 0",
               wq_addr.size(), wq_addr.size() ? wq_addr[0] : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_idle_rvalid();
    clr();
    inject = 1;
    repeat (5) begin
      tick();
      checks++;
      if (busy || m_wen || m_ren) begin
        errors++;
        $display("FAIL idle_rvalid: busy=%b wen=%b ren=%b expected 0 0 0", busy, m_wen, m_ren);
      end
    end
    rq[3].push_back(8'h77);
    model_order();
    present(3);
    run_until_idle("after_rvalid");
    checks++;
    if (n_reads != 1 || wq_data.size() != 1 || wq_data[0] !== 32'h77 || gq[0] != exp_g[0]) begin
      errors++;
      $display("FAIL after_rvalid: reads=%0d writes=%0d data=%h expected 1 1 00000077",
               n_reads, wq_data.size(), wq_data.size() ? wq_data[0] : 0);
    end
  endtask

`ifdef UART_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    clr();
    zeros_left = 100;
    rq[1].push_back(8'h33);
    model_order();
    present(1);
    run_until_idle("timeout");
    checks++;
    if (n_reads != PMAX || wq_data.size() != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: reads=%0d writes=%0d err=%b expected %0d 0 1", n_reads, wq_data.size(), err, PMAX);
    end
    clr();
    zeros_left = 0;
    rq[3].push_back(8'h44);
    model_order();
    present(3);
    run_until_idle("post_timeout");
    checks++;
    if (wq_data.size() != 1 || wq_data[0] !== 32'h44 || err !== 1'b1) begin
      errors++;
      $display("FAIL post_timeout: writes=%0d data=%h err=%b expected 1 00000044 1",
               wq_data.size(), wq_data.size() ? wq_data[0] : 0, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr_static();
    test_random();
    test_reset_mid_write();
    test_idle_rvalid();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter BAUD_SEL, default 2'd0, value written to UART_CTRL.BAUD_SEL at init.
REQ-003 SHALL have parameter POLL_MAX, default 1023, poll-attempt limit (used only with timeout feature).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  NREQ  requester i has a byte pending.
REQ-007 SHALL have port req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_ready  out  NREQ  one-hot one-cycle accept strobe.
REQ-009 SHALL have port m_waddr/m_wdata/m_wstrb  out  32/32/4  UART register write bus.
REQ-010 SHALL have port m_wen  out  1, and m_wready  in  1, write handshake.
REQ-011 SHALL have port m_raddr  out  32, m_ren  out  1, m_rdata  in  32, m_rvalid  in  1, read bus.
REQ-012 SHALL have port busy  out  1  high in any state except IDLE.
REQ-013 SHALL have port err  out  1  sticky timeout flag (0 when feature compiled out).

Function
REQ-014 UART map SHALL be CTRL 0x0, STAT 0x4 (bit0 TX_RDY, bit1 TX_DONE), DATA 0x8 (bits[7:0]).
REQ-015 FSM states SHALL be INIT, IDLE, ARB, POLL_RD, POLL_WAIT, WRITE.
REQ-016 INIT SHALL hold m_wen=1, m_waddr=0x0, m_wdata = UART_EN(bit0)|TX_EN(bit1)|BAUD_SEL at bits[6:5], m_wstrb=4'hF until m_wready=1, then go IDLE.
REQ-017 IDLE SHALL go ARB the cycle after any req_valid is high.
REQ-018 ARB SHALL grant round-robin: first valid index searching from (last_grant+1) mod NREQ; last_grant resets to NREQ-1 (so index 0 wins first).
REQ-019 ARB SHALL pulse req_ready[grant] for exactly one cycle, latch req_data byte, update last_grant, go POLL_RD; if no request remains valid, return IDLE with no strobe.
REQ-020 POLL_RD SHALL drive m_ren=1, m_raddr=0x4 for one cycle, then go POLL_WAIT.
REQ-021 POLL_WAIT SHALL hold m_ren=0 until m_rvalid=1; if m_rdata[0]=1 go WRITE, else go POLL_RD.
REQ-022 WRITE SHALL hold m_wen=1, m_waddr=0x8, m_wdata={24'b0,byte}, m_wstrb=4'h1 until m_wready=1, then go IDLE.
REQ-023 m_wen and m_ren SHALL never be high in the same cycle; outputs other than in their state SHALL be 0.
REQ-024 Latched byte SHALL be written exactly once; requester deasserting req_valid after the strobe SHALL not affect it.
REQ-025 A requester SHALL not be granted twice while another valid requester waits (fairness bound NREQ grants).
REQ-026 m_rvalid arriving outside POLL_WAIT SHALL be ignored.

Reset
REQ-027 While rst=0 SHALL force state INIT, req_ready=0, m_wen=0, m_ren=0, m_waddr/m_wdata/m_raddr=0, m_wstrb=0, busy=1, err=0, last_grant=NREQ-1, byte=0.
REQ-028 Reset mid-transfer SHALL discard the latched byte; INIT re-runs after release.

Configuration
REQ-029 Macro UART_TX_SCHED_TIMEOUT_EN SHALL, when defined, count POLL_RD entries per byte; on reaching POLL_MAX with TX_RDY still 0, drop the byte, set err=1 (sticky until reset), go IDLE.
REQ-030 Without UART_TX_SCHED_TIMEOUT_EN, polling SHALL be unbounded, err tied 0, no counter logic.

Structure
REQ-031 Shared package uart_pkg SHALL hold UART register offsets, STAT/CTRL bit positions and the FSM state encoding.
REQ-032 Sub-module rr_arbiter (parameter N; inputs req, last; output one-hot gnt, index) SHALL implement REQ-018 combinationally.

Verification
REQ-033 Reset release, m_wready after 2 cycles -> one CTRL write 0x00000003|(BAUD_SEL<<5), then busy=0.
REQ-034 req_valid=4'b0001, data 0x41, STAT reads 0 twice then 1 -> three reads of 0x4, one write 0x8 wdata 0x41 wstrb 4'h1.
REQ-035 All four valid continuously, data 0x10..0x13 -> grant order 0,1,2,3,0; DATA writes 0x10,0x11,0x12,0x13,0x10.
REQ-036 rst=0 asserted in WRITE with m_wready low -> m_wen=0 immediately, INIT write after release, no DATA write of the old byte.
REQ-037 TIMEOUT_EN, POLL_MAX=3, STAT always 0 -> exactly 3 reads, no DATA write, err=1, next request proceeds.
REQ-038 m_rvalid pulse while in IDLE -> no state change, no bus activity.
